// File: rtl/ask_serial_deframer_if.sv
// Character output stream of the ASK deframer (AXI-stream style valid/ready).
// master: deframer side, drives o_tdata/o_tvalid and samples o_tready.
// slave : downstream parser side, samples o_tdata/o_tvalid and drives o_tready.
interface ask_serial_deframer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_tdata;
  logic                 o_tvalid;
  logic                 o_tready;

  modport master (output o_tdata, output o_tvalid, input o_tready);
  modport slave  (input o_tdata, input o_tvalid, output o_tready);
endinterface

// File: rtl/ask_serial_deframer.sv
// Purpose : recover async-framed characters (start, DATA_BITS LSB-first, [parity], stop) from the ASK rx level.
// Latency : rx pin to rs = SYNC_STAGES clks; stop-bit mid-sample to o_tvalid = 1 clk.
// Backpres: one-deep output register held until o_tvalid & o_tready; a char finishing while full is dropped (overrun).
// Ports   : clk, reset (sync, active-high), clear (soft reset), enable, rx, clks_per_bit,
//           [parity_odd], axis (master: o_tdata/o_tvalid/o_tready), frame_err, overrun, busy.
// Option  : define ASK_DEFRAMER_PARITY_EN to add a parity bit after the data bits and the parity_odd input.
module ask_serial_deframer #(
  parameter int WIDTH       = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   rx,
  input  logic [WIDTH-1:0]       clks_per_bit,
`ifdef ASK_DEFRAMER_PARITY_EN
  input  logic                   parity_odd,
`endif
  ask_serial_deframer_if.master  axis,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rs;
  logic                   rs_d;
  logic [WIDTH-1:0]       period;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       p_new;
  logic [IW-1:0]          bitidx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   srst;
  logic                   good_char;

  assign srst  = reset | clear;
  assign rs    = sync_q[SYNC_STAGES-1];
  assign busy  = (state != S_IDLE);
  // Bit periods below 4 leave no room for a mid-bit sample point.
  assign p_new = (clks_per_bit < WIDTH'(4)) ? WIDTH'(4) : clks_per_bit;
  // Stop bit sampled high: the character in shreg is complete this cycle.
  assign good_char = enable && (state == S_STOP) && (cnt == '0) && rs;

  // Synchroniser resets to mark so reset never fabricates a start edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= '1;
      rs_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rs_d   <= rs;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= S_IDLE;
      period    <= WIDTH'(4);
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (rs_d && !rs) begin
              state  <= S_START;
              period <= p_new;
              // First sample lands mid start bit, later ones one period apart.
              cnt    <= (p_new >> 1) - WIDTH'(1);
            end
          end
          S_START: begin
            if (cnt != '0) begin
              cnt <= cnt - WIDTH'(1);
            end else if (!rs) begin
              state  <= S_DATA;
              cnt    <= period - WIDTH'(1);
              bitidx <= '0;
            end else begin
              state <= S_IDLE;  // glitch shorter than half a bit
            end
          end
          S_DATA: begin
            if (cnt != '0) begin
              cnt <= cnt - WIDTH'(1);
            end else begin
              // LSB arrives first, so shift in at the top and move right.
              shreg <= DATA_BITS'({rs, shreg} >> 1);
              cnt   <= period - WIDTH'(1);
              if (bitidx == IW'(DATA_BITS - 1)) begin
`ifdef ASK_DEFRAMER_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end else begin
                bitidx <= bitidx + IW'(1);
              end
            end
          end
`ifdef ASK_DEFRAMER_PARITY_EN
          S_PARITY: begin
            if (cnt != '0) begin
              cnt <= cnt - WIDTH'(1);
            end else if ((^shreg ^ rs) != parity_odd) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_STOP;
              cnt   <= period - WIDTH'(1);
            end
          end
`endif
          S_STOP: begin
            if (cnt != '0) begin
              cnt <= cnt - WIDTH'(1);
            end else begin
              // Leaving mid stop bit: the next start needs rs to go 1 then 0.
              state <= S_IDLE;
              if (!rs) frame_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // One-deep output register; a beat leaving on this edge frees the slot.
  always_ff @(posedge clk) begin
    if (srst) begin
      axis.o_tdata  <= '0;
      axis.o_tvalid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (good_char) begin
        if (!axis.o_tvalid || axis.o_tready) begin
          axis.o_tdata  <= shreg;
          axis.o_tvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (axis.o_tvalid && axis.o_tready) begin
        axis.o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ask_serial_deframer.sv
// Bench for ask_serial_deframer: drives framed serial characters on rx and checks the
// recovered stream, frame_err and overrun counts against an expected-character queue.
// Builds with or without ASK_DEFRAMER_PARITY_EN.
module tb_ask_serial_deframer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        enable;
  logic        rx;
  logic [15:0] clks_per_bit;
`ifdef ASK_DEFRAMER_PARITY_EN
  logic        parity_odd;
`endif
  logic        frame_err;
  logic        overrun;
  logic        busy;

  ask_serial_deframer_if #(.DATA_BITS(8)) axis ();

  ask_serial_deframer #(.WIDTH(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .enable       (enable),
    .rx           (rx),
    .clks_per_bit (clks_per_bit),
`ifdef ASK_DEFRAMER_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .axis         (axis),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int bit_p = 16;

  // Monitor: record accepted beats and flag pulses (sampled mid-cycle).
  logic [7:0] rxq[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (axis.o_tvalid && axis.o_tready) rxq.push_back(axis.o_tdata);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  // Scoreboard state per test.
  logic [7:0] expq[$];
  int rx_base, fe_base, ov_base, exp_fe, exp_ov;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_period(input int cpb);
    clks_per_bit = 16'(cpb);
    bit_p = (cpb < 4) ? 4 : cpb;
  endtask

  task automatic sb_start();
    expq.delete();
    rx_base = rxq.size();
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    exp_fe  = 0;
    exp_ov  = 0;
  endtask

  // One frame: start, 8 data LSB first, [parity], stop; line left at mark.
  task automatic send_char(input logic [7:0] d, input logic stop_v, input logic par_flip);
    rx = 1'b0;
    tick(bit_p);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(bit_p);
    end
`ifdef ASK_DEFRAMER_PARITY_EN
    rx = (^d) ^ parity_odd ^ par_flip;
    tick(bit_p);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_v;
    tick(bit_p);
    rx = 1'b1;
  endtask

  task automatic sb_check(input string name);
    int got_n;
    got_n = rxq.size() - rx_base;
    total++;
    if (got_n !== expq.size()) begin
      bad++;
      $display("FAIL %s_beats: got=%0d want=%0d", name, got_n, expq.size());
    end
    for (int i = 0; i < expq.size() && i < got_n; i++) begin
      total++;
      if (rxq[rx_base + i] !== expq[i]) begin
        bad++;
        $display("FAIL %s_data[%0d]: got=%h want=%h", name, i, rxq[rx_base + i], expq[i]);
      end
    end
    total++;
    if ((fe_cnt - fe_base) !== exp_fe) begin
      bad++;
      $display("FAIL %s_frame_err: got=%0d want=%0d", name, fe_cnt - fe_base, exp_fe);
    end
    total++;
    if ((ov_cnt - ov_base) !== exp_ov) begin
      bad++;
      $display("FAIL %s_overrun: got=%0d want=%0d", name, ov_cnt - ov_base, exp_ov);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; enable = 1'b1; rx = 1'b1;
    axis.o_tready = 1'b1;
    set_period(16);
    tick(3);
    total++;
    if ({axis.o_tvalid, axis.o_tdata, frame_err, overrun, busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state: got tv=%b td=%h fe=%b ov=%b busy=%b want all 0",
               axis.o_tvalid, axis.o_tdata, frame_err, overrun, busy);
    end
    reset = 1'b0;
    tick(6);
    total++;
    if (busy !== 1'b0 || axis.o_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b tv=%b want 0 0", busy, axis.o_tvalid);
    end
  endtask

  task automatic test_basic();
    sb_start();
    fork
      send_char(8'hA5, 1'b1, 1'b0);
      begin
        tick(3 * bit_p);
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL basic_busy: got=%b want=1", busy);
        end
      end
    join
    expq.push_back(8'hA5);
    tick(2 * bit_p);
    sb_check("basic");
  endtask

  // Start edge driven after edge 0; stop sample edge = 3 + P/2 + 9P (+P with parity).
  task automatic test_latency();
    int lat;
    sb_start();
    axis.o_tready = 1'b0;
    lat = 3 + bit_p / 2 + 9 * bit_p;
`ifdef ASK_DEFRAMER_PARITY_EN
    lat = lat + bit_p;
`endif
    fork
      send_char(8'h6B, 1'b1, 1'b0);
      begin
        tick(lat - 1);
        total++;
        if (axis.o_tvalid !== 1'b0) begin
          bad++;
          $display("FAIL latency_early: got tv=%b want 0", axis.o_tvalid);
        end
        tick(1);
        total++;
        if (axis.o_tvalid !== 1'b1 || axis.o_tdata !== 8'h6B) begin
          bad++;
          $display("FAIL latency_valid: got tv=%b td=%h want 1 6b", axis.o_tvalid, axis.o_tdata);
        end
      end
    join
    tick(5);
    axis.o_tready = 1'b1;
    tick(2);
    expq.push_back(8'h6B);
    sb_check("latency");
  endtask

  task automatic test_glitch();
    sb_start();
    rx = 1'b0;
    tick(5);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy_on: got=%b want=1", busy);
    end
    rx = 1'b1;
    tick(3 * bit_p);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy_off: got=%b want=0", busy);
    end
    sb_check("glitch");
  endtask

  task automatic test_frame_err();
    sb_start();
    send_char(8'h3C, 1'b0, 1'b0);
    exp_fe++;
    tick(2 * bit_p);
    send_char(8'h81, 1'b1, 1'b0);
    expq.push_back(8'h81);
    tick(2 * bit_p);
    sb_check("frame_err");
  endtask

  task automatic test_overrun();
    sb_start();
    axis.o_tready = 1'b0;
    send_char(8'h3C, 1'b1, 1'b0);
    send_char(8'h7E, 1'b1, 1'b0);
    exp_ov++;
    tick(2 * bit_p);
    total++;
    if (axis.o_tvalid !== 1'b1 || axis.o_tdata !== 8'h3C) begin
      bad++;
      $display("FAIL overrun_hold: got tv=%b td=%h want 1 3c", axis.o_tvalid, axis.o_tdata);
    end
    axis.o_tready = 1'b1;
    tick(3);
    total++;
    if (axis.o_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL overrun_drain: got tv=%b want 0", axis.o_tvalid);
    end
    expq.push_back(8'h3C);
    sb_check("overrun");
  endtask

  // mode 0: reset, 1: enable low, 2: clear -- applied halfway through data bit 4.
  task automatic test_abort(input int mode);
    logic [7:0] d;
    sb_start();
    d = 8'hEF;
    rx = 1'b0;
    tick(bit_p);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(bit_p);
    end
    rx = d[4];
    tick(bit_p / 2);
    if (mode == 1) begin
      enable = 1'b0;
      tick(1);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL abort%0d_busy_next: got=%b want=0", mode, busy);
      end
      rx = 1'b1;
      tick(3);
      enable = 1'b1;
    end else begin
      if (mode == 0) reset = 1'b1;
      else clear = 1'b1;
      rx = 1'b1;
      tick(2);
      reset = 1'b0;
      clear = 1'b0;
    end
    tick(2 * bit_p);
    total++;
    if (busy !== 1'b0 || axis.o_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL abort%0d_quiet: got busy=%b tv=%b want 0 0", mode, busy, axis.o_tvalid);
    end
    send_char(8'h55, 1'b1, 1'b0);
    expq.push_back(8'h55);
    tick(2 * bit_p);
    sb_check($sformatf("abort%0d", mode));
  endtask

  // clks_per_bit below 4 behaves as a 4-clock bit.
  task automatic test_small_period();
    logic [7:0] d;
    sb_start();
    set_period(2);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_char(d, 1'b1, 1'b0);
      expq.push_back(d);
    end
    tick(4 * bit_p);
    sb_check("small_period");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop_v;
    int         gap;
    sb_start();
    for (int n = 0; n < 24; n++) begin
      set_period($urandom_range(0, 24));
      d      = 8'($urandom);
      stop_v = ($urandom_range(0, 5) != 0);
      // A bad stop bit needs a mark before the next start edge.
      gap    = stop_v ? $urandom_range(0, 2 * bit_p) : bit_p + $urandom_range(0, bit_p);
      fork
        send_char(d, stop_v, 1'b0);
        begin
          tick(3 * bit_p);
          clks_per_bit = 16'($urandom_range(4, 40));  // must be ignored mid-char
        end
      join
      if (stop_v) expq.push_back(d);
      else exp_fe++;
      tick(gap);
    end
    tick(3 * bit_p);
    sb_check("random");
  endtask

`ifdef ASK_DEFRAMER_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    logic       flip;
    sb_start();
    set_period(16);
    parity_odd = 1'b0;
    send_char(8'h03, 1'b1, 1'b0);
    expq.push_back(8'h03);
    tick(bit_p);
    send_char(8'h03, 1'b1, 1'b1);
    exp_fe++;
    tick(bit_p);
    parity_odd = 1'b1;
    for (int n = 0; n < 6; n++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(0, 2) == 0);
      send_char(d, 1'b1, flip);
      if (flip) exp_fe++;
      else expq.push_back(d);
      tick($urandom_range(0, bit_p));
    end
    parity_odd = 1'b0;
    tick(2 * bit_p);
    sb_check("parity");
  endtask
`endif

  initial begin
`ifdef ASK_DEFRAMER_PARITY_EN
    parity_odd = 1'b0;
`endif
    test_reset();
    test_basic();
    test_latency();
    test_glitch();
    test_frame_err();
    test_overrun();
    for (int m = 0; m < 3; m++) test_abort(m);
    test_small_period();
    test_random();
`ifdef ASK_DEFRAMER_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
